iccm_dump_tx: RTL and testbench
===============================

// Module: iccm_dump_tx
// PURPOSE
//  UART readback transmitter, the reader counterpart of the ICCM programming path.
//  The programming path receives bytes on UART and writes ICCM; this block reads N ICCM words and sends them out.
//  Each word goes out as 4 bytes, little-endian (byte0 first), 8N1, LSB first, idle high.
//  Runs from the same clock as the programming path and sits beside the ICCM controller on its read port.
//  Used to verify a downloaded image.
// PARAMETERS
//  ADDR_W   12   ICCM word-address width
//  DATA_W   32   ICCM word width; fixed at 32 (4 bytes per word)
//  MIN_CPB  4    minimum clocks per bit; smaller requests are clamped up to this value
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_ni          in   1       asynchronous active-low reset
//  start_i         in   1       1-cycle start pulse; honoured only when busy_o=0
//  base_addr_i     in   ADDR_W  first word address; sampled on start
//  word_count_i    in   ADDR_W  number of words to send; sampled on start
//  clks_per_bit_i  in   16      baud divisor; sampled on start
//  mem_req_o       out  1       read strobe to ICCM, 1 cycle wide
//  mem_addr_o      out  ADDR_W  read address; valid while mem_req_o=1
//  mem_rdata_i     in   DATA_W  read data; valid exactly 1 cycle after mem_req_o
//  uart_tx_o       out  1       serial output
//  busy_o          out  1       high from the cycle after an accepted start until done_o
//  done_o          out  1       1-cycle pulse when the dump completes
// BEHAVIOUR
//  Reset values: uart_tx_o=1; mem_req_o=0; mem_addr_o=0; busy_o=0; done_o=0.
//  Reset mid-dump aborts at once; the line returns to idle high asynchronously.
//  Registers:
//   - addr, words_left (ADDR_W)
//   - cpb (16, clamped to >=MIN_CPB)
//   - shift word (32), byte_idx (2b), bit_idx (3b), baud_cnt (16)
//  State IDLE:
//   - on start_i with word_count_i!=0: latch inputs -> READ.
//   - on start_i with word_count_i==0: done_o pulses the next cycle, busy_o stays 0, no mem_req_o.
//  State READ: mem_req_o=1, mem_addr_o=addr -> WAIT.
//  State WAIT: capture mem_rdata_i into the word register; byte_idx=0 -> START.
//  Bit period: each of START, DATA and STOP lasts exactly cpb clocks (baud_cnt counts 0..cpb-1).
//  State START: uart_tx_o=0 -> DATA.
//  State DATA: uart_tx_o=word[8*byte_idx+bit_idx], bits 0..7 in order -> STOP after bit 7.
//  State STOP: uart_tx_o=1. At its end:
//   - byte_idx<3: byte_idx++ -> START (no idle gap between bytes).
//   - byte_idx==3: words_left--, addr++ ->
//       - words_left (after decrement) !=0: READ.
//       - words_left ==0: DONE.
//  Inter-word gap: READ+WAIT adds exactly 2 idle-high cycles between word frames.
//  State DONE: done_o=1 for 1 cycle, busy_o=0 -> IDLE.
//  Address arithmetic: addr wraps modulo 2^ADDR_W (0xFFF+1 -> 0x000); there is no error.
//  start_i while busy_o=1 is ignored; latched config is unaffected.
//  Input changes after sampling have no effect until the next start.
//  Timing per word: 2 + 4*10*cpb clocks.
//  Latency: start accepted in cycle T -> mem_req_o in cycle T+1 -> start bit begins at T+3.
// TESTING
//  Reset: hold rst_ni=0 -> uart_tx_o=1, busy_o=0, mem_req_o=0; assert rst_ni mid-DATA -> line goes high at once.
//  Single word: base=0, count=1, cpb=4, ICCM[0]=0xA5C30F01 ->
//   - bytes 0x01,0x0F,0xC3,0xA5, each 40 clocks
//   - done_o at T+3+160
//  Multi-word: base=0x010, count=3 ->
//   - mem_addr_o reads 0x010,0x011,0x012, one mem_req_o each
//   - 12 bytes decoded correctly; 2-cycle idle gap between words
//  Wrap: base=0xFFF, count=2 -> reads 0xFFF then 0x000.
//  Edges:
//   - count=0 -> done_o pulse, no mem_req_o, line stays idle
//   - cpb=1 -> bit period 4 clocks
//  Busy: second start_i mid-dump with different base -> ignored; original sequence completes unchanged.
//  Loopback: feed uart_tx_o to the programming UART receiver at CLKS_PER_BIT=1667 -> received bytes equal ICCM contents.

Source files
------------

// File: rtl/iccm_dump_tx.sv
// -----------------------------------------------------------------------------
// iccm_dump_tx
//
// UART readback transmitter for ICCM. On an accepted start it reads
// word_count_i consecutive ICCM words beginning at base_addr_i. Each word is
// sent as four bytes, byte0 first. Each byte is framed 8N1, LSB first, and the
// line idles high. This block is used to verify an image that was downloaded
// through the programming path. It runs on the same clock as that path.
//
// Ports
//   clk_i           in   1       clock, rising edge
//   rst_ni          in   1       asynchronous active-low reset
//   start_i         in   1       start pulse, honoured only while busy_o=0
//   base_addr_i     in   ADDR_W  first word address, sampled on start
//   word_count_i    in   ADDR_W  number of words to send, sampled on start
//   clks_per_bit_i  in   16      baud divisor, sampled on start (clamped)
//   mem_req_o       out  1       one-cycle ICCM read strobe
//   mem_addr_o      out  ADDR_W  ICCM read address (valid with mem_req_o)
//   mem_rdata_i     in   DATA_W  ICCM read data, valid 1 cycle after mem_req_o
//   uart_tx_o       out  1       serial output
//   busy_o          out  1       dump in progress
//   done_o          out  1       one-cycle completion pulse
//
// Handshake: there is no back-pressure. A start is a single-cycle request.
// It is taken only in a cycle where busy_o=0. The ICCM read is fixed-latency:
// data is captured exactly one cycle after mem_req_o, with no ready signal.
// -----------------------------------------------------------------------------
module iccm_dump_tx #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MIN_CPB = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] word_count_i,
    input  logic [15:0]       clks_per_bit_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              uart_tx_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [15:0]       MIN_CPB_W = 16'(MIN_CPB);

    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [ADDR_W-1:0]   words_left_q, words_left_d;
    logic [15:0]         cpb_q,        cpb_d;
    logic [DATA_W-1:0]   word_q,       word_d;
    logic [1:0]          byte_idx_q,   byte_idx_d;
    logic [2:0]          bit_idx_q,    bit_idx_d;
    logic [15:0]         baud_cnt_q,   baud_cnt_d;

    // Last clock of the current bit period (START, DATA or STOP).
    logic bit_end;
    assign bit_end = (baud_cnt_q == (cpb_q - 16'd1));

    // The divisor is clamped when it is latched. The baud counter therefore
    // never sees a period shorter than MIN_CPB.
    logic [15:0] cpb_clamped;
    assign cpb_clamped = (clks_per_bit_i < MIN_CPB_W) ? MIN_CPB_W : clks_per_bit_i;

    assign mem_addr_o = addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            cpb_q        <= MIN_CPB_W;
            word_q       <= '0;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            baud_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            cpb_q        <= cpb_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
        end
    end

    // Outputs are decoded from the state register. Because of this, an
    // asynchronous reset returns the line to idle high without waiting for
    // a clock edge.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        cpb_d        = cpb_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = baud_cnt_q;
        mem_req_o    = 1'b0;
        uart_tx_o    = 1'b1;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            // DONE is not busy, so it accepts a new start exactly like IDLE.
            S_IDLE, S_DONE: begin
                done_o  = (state_q == S_DONE);
                state_d = S_IDLE;
                if (start_i) begin
                    if (word_count_i != ADDR_ZERO) begin
                        addr_d       = base_addr_i;
                        words_left_d = word_count_i;
                        cpb_d        = cpb_clamped;
                        state_d      = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_READ: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                busy_o     = 1'b1;
                word_d     = mem_rdata_i;
                byte_idx_d = 2'd0;
                bit_idx_d  = 3'd0;
                baud_cnt_d = 16'd0;
                state_d    = S_START;
            end

            S_START: begin
                busy_o    = 1'b1;
                uart_tx_o = 1'b0;
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                busy_o    = 1'b1;
                uart_tx_o = word_q[{byte_idx_q, bit_idx_q}];
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            S_STOP: begin
                busy_o    = 1'b1;
                uart_tx_o = 1'b1;
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    if (byte_idx_q != 2'd3) begin
                        // The next byte's start bit follows immediately.
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START;
                    end else begin
                        // The address wraps naturally at 2^ADDR_W.
                        words_left_d = words_left_q - ADDR_ONE;
                        addr_d       = addr_q + ADDR_ONE;
                        state_d      = (words_left_q == ADDR_ONE) ? S_DONE : S_READ;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iccm_dump_tx.sv
module tb_iccm_dump_tx;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        start_i = 1'b0;
  logic [11:0] base_addr_i = '0;
  logic [11:0] word_count_i = '0;
  logic [15:0] clks_per_bit_i = 16'd4;
  logic        mem_req_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_rdata = '0;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;

  iccm_dump_tx #(.ADDR_W(12), .DATA_W(32), .MIN_CPB(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .word_count_i   (word_count_i),
    .clks_per_bit_i (clks_per_bit_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rdata_i    (mem_rdata),
    .uart_tx_o      (uart_tx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  // ---------------- ICCM model: data valid 1 cycle after request ----------------
  logic [31:0] iccm [4096];

  // Outside a read response the bus carries random junk. A capture taken
  // in the wrong cycle therefore shows up as wrong data.
  always @(posedge clk) begin
    if (mem_req_o) mem_rdata <= iccm[mem_addr_o];
    else           mem_rdata <= $urandom();
  end

  // ---------------- monitors ----------------
  bit          mon_en = 1'b0;
  int          mon_cpb = 4;
  logic [7:0]  got_q[$];
  int          got_cyc_q[$];
  bit          got_ok_q[$];
  logic [11:0] req_addr_q[$];
  int          req_cyc_q[$];
  int          done_cyc_q[$];
  int          busy_cnt = 0;

  // Bus-side monitor: read strobes, done pulses and busy cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (done_o === 1'b1) done_cyc_q.push_back(cyc);
        if (mem_req_o === 1'b1) begin
          req_addr_q.push_back(mem_addr_o);
          req_cyc_q.push_back(cyc);
        end
        if (busy_o === 1'b1) busy_cnt = busy_cnt + 1;
      end
    end
  end

  // UART decoder. It samples at mid-bit with the expected divisor and
  // records each byte's first start-bit cycle and its framing result.
  initial begin
    forever begin : dec
      int         st;
      logic [7:0] b;
      bit         ok;
      @(negedge clk);
      if (mon_en && rst_n && uart_tx_o === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        b  = '0;
        repeat (mon_cpb / 2) @(negedge clk);
        if (uart_tx_o !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (mon_cpb) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (mon_cpb) @(negedge clk);
        if (uart_tx_o !== 1'b1) ok = 1'b0;
        got_q.push_back(b);
        got_cyc_q.push_back(st);
        got_ok_q.push_back(ok);
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [11:0] exp_addr_q[$];
  int          exp_req_cyc_q[$];

  task automatic clear_obs();
    got_q.delete();
    got_cyc_q.delete();
    got_ok_q.delete();
    req_addr_q.delete();
    req_cyc_q.delete();
    done_cyc_q.delete();
    busy_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Raises start for one cycle. t returns the cycle in which start is sampled.
  // Afterwards the config inputs are scrambled; they must not matter any more.
  task automatic drive_start(input logic [11:0] base, input logic [11:0] count,
                             input logic [15:0] cpb, output int t);
    @(negedge clk);
    base_addr_i    = base;
    word_count_i   = count;
    clks_per_bit_i = cpb;
    start_i        = 1'b1;
    t              = cyc;
    @(negedge clk);
    start_i        = 1'b0;
    base_addr_i    = 12'($urandom());
    word_count_i   = 12'($urandom());
    clks_per_bit_i = 16'($urandom_range(1, 12));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", uart_tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done_o); end
    total++; if (mem_addr_o !== 12'h000) begin bad++; $display("FAIL reset_addr: got %h expected 000", mem_addr_o); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
  endtask

  // One complete dump, checked against a reference built from the framing
  // rules: 2 idle cycles then 4 frames of 10 bit periods per word.
  // With poke=1, a conflicting start is issued mid-dump.
  task automatic test_dump(input string name, input logic [11:0] base,
                           input logic [11:0] count, input logic [15:0] cpb_in,
                           input bit poke);
    int          c;
    int          t;
    int          word_len;
    int          exp_done;
    int          lim;
    logic [11:0] a;
    int          n;
    c = (cpb_in < 16'd4) ? 4 : int'(cpb_in);
    mon_cpb = c;
    word_len = 40 * c + 2;
    clear_obs();
    exp_q.delete(); exp_cyc_q.delete(); exp_addr_q.delete(); exp_req_cyc_q.delete();

    drive_start(base, count, cpb_in, t);

    for (int w = 0; w < int'(count); w++) begin
      a = base + 12'(w);
      exp_addr_q.push_back(a);
      exp_req_cyc_q.push_back(t + 1 + w * word_len);
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(iccm[a][8*b +: 8]);
        exp_cyc_q.push_back(t + 3 + w * word_len + b * 10 * c);
      end
    end
    exp_done = t + 1 + int'(count) * word_len;

    if (poke) begin
      repeat (40) @(negedge clk);
      base_addr_i    = 12'h300;
      word_count_i   = 12'd5;
      clks_per_bit_i = 16'd9;
      start_i        = 1'b1;
      @(negedge clk);
      start_i        = 1'b0;
    end

    lim = int'(count) * word_len + 50;
    n = 0;
    while (done_cyc_q.size() == 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);

    total++;
    if (done_cyc_q.size() != 1) begin
      bad++; $display("FAIL %s done_count: got %0d expected 1", name, done_cyc_q.size());
    end else begin
      total++;
      if (done_cyc_q[0] != exp_done) begin
        bad++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc_q[0] - t, exp_done - t);
      end
    end
    total++;
    if (busy_cnt != exp_done - t - 1) begin
      bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_done - t - 1);
    end
    total++;
    if (req_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL %s req_count: got %0d expected %0d", name, req_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        total++;
        if (req_addr_q[i] !== exp_addr_q[i] || req_cyc_q[i] != exp_req_cyc_q[i]) begin
          bad++;
          $display("FAIL %s req[%0d]: got addr %h at +%0d expected addr %h at +%0d",
                   name, i, req_addr_q[i], req_cyc_q[i] - t, exp_addr_q[i], exp_req_cyc_q[i] - t);
        end
      end
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s byte_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i] || got_ok_q[i] != 1'b1) begin
          bad++;
          $display("FAIL %s byte[%0d]: got %h at +%0d frame_ok=%0d expected %h at +%0d frame_ok=1",
                   name, i, got_q[i], got_cyc_q[i] - t, got_ok_q[i], exp_q[i], exp_cyc_q[i] - t);
        end
      end
    end
  endtask

  task automatic test_zero_count();
    int t;
    clear_obs();
    drive_start(12'h055, 12'd0, 16'd4, t);
    repeat (20) @(negedge clk);
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != t + 1) begin
      bad++; $display("FAIL zero_done: got %0d pulses (first at +%0d) expected 1 at +1",
                      done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - t : -1);
    end
    total++; if (busy_cnt != 0) begin bad++; $display("FAIL zero_busy: got %0d expected 0", busy_cnt); end
    total++; if (req_addr_q.size() != 0) begin bad++; $display("FAIL zero_req: got %0d expected 0", req_addr_q.size()); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL zero_line: got %0d frames expected 0", got_q.size()); end
  endtask

  task automatic test_reset_mid_data();
    int t;
    int lows;
    int dones;
    mon_en = 1'b0;
    iccm[12'h100] = 32'h0000_0000;
    drive_start(12'h100, 12'd1, 16'd4, t);
    // We are at cycle t+1; move to the middle of data bit 0 (t+3+4+2).
    repeat (8) @(negedge clk);
    total++; if (uart_tx_o !== 1'b0) begin bad++; $display("FAIL midrst_pre_tx: got %b expected 0", uart_tx_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL midrst_tx: got %b expected 1", uart_tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1) lows++;
      if (done_o !== 1'b0) dones++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL midrst_idle: got %0d non-idle cycles expected 0", lows); end
    total++; if (dones != 0) begin bad++; $display("FAIL midrst_done: got %0d done cycles expected 0", dones); end
    clear_obs();
    mon_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) iccm[i] = $urandom();
    iccm[12'h000] = 32'hA5C3_0F01;

    test_reset();
    test_dump("single", 12'h000, 12'd1, 16'd4, 1'b0);
    test_dump("multi", 12'h010, 12'd3, 16'($urandom_range(4, 8)), 1'b0);
    test_dump("wrap", 12'hFFF, 12'd2, 16'd1, 1'b0);
    test_dump("cpb0", 12'h123, 12'd1, 16'd0, 1'b0);
    test_dump("busy", 12'h010, 12'd2, 16'd6, 1'b1);
    test_zero_count();
    for (int r = 0; r < 3; r++) begin
      test_dump("random", 12'($urandom()), 12'($urandom_range(1, 3)),
                16'($urandom_range(0, 10)), 1'b0);
    end
    test_dump("back_to_back", 12'h200, 12'd1, 16'd5, 1'b0);
    test_reset_mid_data();
    test_dump("after_reset", 12'h7F0, 12'd2, 16'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
